prog_countdown_timer: RTL and testbench
=======================================

PROG_COUNTDOWN_TIMER -- requirements
Module: prog_countdown_timer

Interface
REQ-001 Parameter WIDTH, default 7, SHALL set the width of the count and the load value.
REQ-002 Parameter INIT_COUNT, default 9, SHALL set the count value after reset (must be < 2**WIDTH).
REQ-003 Parameter TICK_DIV, default 50_000_000, SHALL set the number of clk cycles per count step (must be >= 1).
REQ-004 clk  input  1  SHALL be the clock; all state changes on the rising edge.
REQ-005 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-006 load  input  1  SHALL, when high for one cycle, copy load_value into count and the reload register.
REQ-007 load_value  input  WIDTH  SHALL carry the value sampled when load is high.
REQ-008 start  input  1  SHALL, when high for one cycle, begin or resume counting.
REQ-009 pause  input  1  SHALL, while high, freeze the count and the prescaler.
REQ-010 auto_reload  input  1  SHALL select the mode on expiry: 1 = reload and continue; 0 = stop.
REQ-011 count  output  WIDTH  SHALL be the current remaining count, driven from a register.
REQ-012 running  output  1  SHALL be high in RUN.
REQ-013 expired  output  1  SHALL be a single-cycle pulse when the count reaches 0.
REQ-014 done  output  1  SHALL be high in DONE.

Function
REQ-015 States SHALL be IDLE, RUN, PAUSED and DONE.
REQ-016 Input priority each cycle SHALL be load > start > pause.
REQ-017 load SHALL:
- set count and the reload register to load_value;
- clear the prescaler;
- move to IDLE from any state.
REQ-018 start SHALL move IDLE or PAUSED to RUN; start in RUN or DONE SHALL be ignored.
REQ-019 pause high in RUN SHALL move to PAUSED; PAUSED SHALL return to RUN only on start.
REQ-020 The prescaler SHALL:
- count 0..TICK_DIV-1 in RUN only;
- hold its value in PAUSED;
- be cleared in IDLE and DONE.
REQ-021 An internal tick SHALL assert in the cycle the prescaler equals TICK_DIV-1 in RUN; the prescaler then wraps to 0.
REQ-022 On a tick with count > 1, count SHALL decrement by 1.
REQ-023 On a tick with count == 1, count SHALL become 0 and expired SHALL pulse in the following cycle. The state then SHALL go to:
- DONE when auto_reload == 0;
- RUN when auto_reload == 1, with count := reload register on the next tick boundary (no extra wait cycles).
REQ-024 Entering RUN with count == 0 SHALL expire without waiting for a tick:
- expired SHALL pulse one cycle after start;
- with auto_reload == 1 and a reload value of 0, the block SHALL go to DONE (no infinite pulsing).
REQ-025 count SHALL never wrap below 0; no arithmetic SHALL exceed WIDTH bits.
REQ-026 auto_reload SHALL be sampled at the expiry tick only.
REQ-027 load in the same cycle as a tick SHALL win: no decrement and no expired pulse.

Reset
REQ-028 reset SHALL force the following, independent of clk:
- state IDLE;
- count and reload register = INIT_COUNT;
- prescaler = 0;
- running, expired and done = 0.
REQ-029 reset asserted mid-RUN SHALL abort counting with no expired pulse; after release, the block SHALL wait for start.

Structure
REQ-030 Package timer_pkg SHALL hold the state enum and a clog2-based prescaler width constant.
REQ-031 The prescaler SHALL be the sub-module tick_prescaler, with:
- parameter DIV;
- inputs clk, reset, enable, clear;
- output tick.

Verification (TICK_DIV=4, WIDTH=7)
REQ-032 reset, then start -> count 9,8,...,0 stepping every 4 cycles; expired pulses once; done = 1 and count holds 0.
REQ-033 load_value=3 with load, start, pause high for 10 cycles after the first step -> count holds 2 for 10 cycles, then resumes on start with its prescaler phase preserved.
REQ-034 auto_reload=1, load 2, start -> count sequence 2,1,0,2,1,0; expired pulses every 8 cycles; done stays 0.
REQ-035 load 0, start -> expired one cycle after start; done = 1 with auto_reload at 0 and at 1.
REQ-036 reset asserted mid-count (count=5) -> count = 9 and state IDLE immediately; no expired pulse.
REQ-037 load coincident with the final tick (count=1) -> count = load_value, no expired pulse, state IDLE.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared types and helpers for the programmable countdown timer.
//   state_t      - controller states (IDLE, RUN, PAUSED, DONE)
//   presc_width  - prescaler counter width for a given divide ratio (min 1 bit)
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int unsigned presc_width(input int unsigned div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

  localparam int unsigned DEFAULT_TICK_DIV = 50_000_000;
  localparam int unsigned DEFAULT_PRESC_W  = presc_width(DEFAULT_TICK_DIV);

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: counts 0..DIV-1 while enabled and flags the last cycle.
//   clk    - clock, rising edge
//   reset  - asynchronous, active-high; counter to 0
//   enable - advance the counter this cycle (holds otherwise)
//   clear  - synchronous clear to 0, wins over enable
//   tick   - high in the enabled cycle where the counter equals DIV-1
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned W = presc_width(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/prog_countdown_timer.sv
// prog_countdown_timer: loadable countdown timer with pause and auto-reload.
//   clk, reset   - clock (rising edge) and asynchronous active-high reset
//   load         - copy load_value into count and reload register, go IDLE
//   load_value   - value captured on load
//   start        - begin/resume counting from IDLE or PAUSED
//   pause        - while high, freeze count and prescaler (RUN -> PAUSED)
//   auto_reload  - on expiry: 1 = reload and keep running, 0 = stop in DONE
//   count        - remaining count (registered)
//   running      - high in RUN
//   expired      - one-cycle pulse the cycle after the count reaches 0
//   done         - high in DONE
module prog_countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH      = 7,
  parameter int unsigned INIT_COUNT = 9,
  parameter int unsigned TICK_DIV   = 50_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             expired,
  output logic             done
);

  localparam logic [WIDTH-1:0] INIT = WIDTH'(INIT_COUNT);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] count_nx;
  logic [WIDTH-1:0] reload, reload_nx;
  logic             expired_nx;
  logic             pause_eff;
  logic             presc_en, presc_clr, tick;

  // load beats start beats pause; start in RUN is a no-op that still masks pause.
  assign pause_eff = pause && !start && !load;
  assign presc_en  = (state == RUN) && !load && !pause_eff;
  assign presc_clr = load || (state == IDLE) || (state == DONE);

  tick_prescaler #(.DIV(TICK_DIV)) u_presc (
    .clk    (clk),
    .reset  (reset),
    .enable (presc_en),
    .clear  (presc_clr),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= INIT;
      reload  <= INIT;
      expired <= 1'b0;
    end else begin
      state   <= state_nx;
      count   <= count_nx;
      reload  <= reload_nx;
      expired <= expired_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    count_nx   = count;
    reload_nx  = reload;
    expired_nx = 1'b0;
    if (load) begin
      count_nx  = load_value;
      reload_nx = load_value;
      state_nx  = IDLE;
    end else begin
      case (state)
        IDLE, PAUSED: begin
          if (start) begin
            if (count == '0) begin
              // Starting on zero expires at once; a zero reload cannot restart.
              expired_nx = 1'b1;
              state_nx   = (auto_reload && reload != '0) ? RUN : DONE;
            end else begin
              state_nx = RUN;
            end
          end
        end
        RUN: begin
          if (count == '0) begin
            // Zero in RUN only follows an auto-reload expiry: refill in this
            // single cycle while the prescaler keeps its phase.
            if (reload == '0) begin
              state_nx = DONE;
            end else begin
              count_nx = reload;
              if (pause_eff) state_nx = PAUSED;
            end
          end else if (pause_eff) begin
            state_nx = PAUSED;
          end else if (tick) begin
            if (count == ONE) begin
              count_nx   = '0;
              expired_nx = 1'b1;
              if (!auto_reload || reload == '0) state_nx = DONE;
            end else begin
              count_nx = count - ONE;
            end
          end
        end
        DONE: ;
        default: state_nx = IDLE;
      endcase
    end
  end

  assign running = (state == RUN);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_prog_countdown_timer.sv
module tb_prog_countdown_timer;

  localparam int TICK_DIV = 4;
  localparam int WIDTH    = 7;
  localparam int INIT     = 9;

  localparam int S_IDLE   = 0;
  localparam int S_RUN    = 1;
  localparam int S_PAUSED = 2;
  localparam int S_DONE   = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_value = '0;
  logic             start = 1'b0;
  logic             pause = 1'b0;
  logic             auto_reload = 1'b0;
  logic [WIDTH-1:0] count;
  logic             running, expired, done;

  int checks = 0;
  int errors = 0;

  // Reference model state (plain integers)
  int m_state, m_count, m_reload, m_phase, m_expired;

  prog_countdown_timer #(
    .WIDTH      (WIDTH),
    .INIT_COUNT (INIT),
    .TICK_DIV   (TICK_DIV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .load_value  (load_value),
    .start       (start),
    .pause       (pause),
    .auto_reload (auto_reload),
    .count       (count),
    .running     (running),
    .expired     (expired),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = S_IDLE; m_count = INIT; m_reload = INIT; m_phase = 0; m_expired = 0;
  endtask

  // One rising edge of the timer, described in terms of the behavioural rules.
  task automatic model_step();
    int exp_n;
    bit hold;
    exp_n = 0;
    if (load) begin
      m_count = int'(load_value); m_reload = int'(load_value); m_phase = 0; m_state = S_IDLE;
    end else begin
      case (m_state)
        S_IDLE, S_PAUSED: begin
          if (m_state == S_IDLE) m_phase = 0;
          if (start) begin
            if (m_count == 0) begin
              exp_n = 1;
              m_state = (auto_reload && m_reload > 0) ? S_RUN : S_DONE;
            end else m_state = S_RUN;
          end
        end
        S_RUN: begin
          hold = pause && !start;
          if (m_count == 0) begin
            if (m_reload == 0) m_state = S_DONE;
            else begin
              m_count = m_reload;
              if (hold) m_state = S_PAUSED;
            end
            if (!hold) m_phase = (m_phase + 1) % TICK_DIV;
          end else if (hold) begin
            m_state = S_PAUSED;
          end else begin
            if (m_phase == TICK_DIV - 1) begin
              if (m_count == 1) begin
                m_count = 0; exp_n = 1;
                if (!auto_reload || m_reload == 0) m_state = S_DONE;
              end else m_count = m_count - 1;
            end
            m_phase = (m_phase + 1) % TICK_DIV;
          end
        end
        default: m_phase = 0;
      endcase
    end
    m_expired = exp_n;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) model_reset(); else model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    #2;
    checks++; if (count !== 7'(INIT)) begin errors++; $display("FAIL reset_count: got %0d expected %0d", count, INIT); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", running); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (expired !== 1'b0) begin errors++; $display("FAIL reset_expired: got %b expected 0", expired); end
    cycle(); cycle();
    reset = 1'b0;
    cycle();
    checks++; if (count !== 7'(INIT) || running !== 1'b0) begin
      errors++; $display("FAIL reset_release: got count %0d running %b expected %0d 0", count, running, INIT);
    end
  endtask

  task automatic test_countdown();
    int npulse;
    npulse = 0;
    start = 1'b1; cycle(); start = 1'b0;
    for (int v = INIT; v >= 1; v--) begin
      for (int j = 0; j < TICK_DIV; j++) begin
        checks++; if (count !== 7'(v) || running !== 1'b1) begin
          errors++; $display("FAIL countdown_step: got count %0d running %b expected %0d 1", count, running, v);
        end
        if (expired) npulse++;
        cycle();
      end
    end
    checks++; if (expired !== 1'b1 || done !== 1'b1 || count !== 7'd0) begin
      errors++; $display("FAIL countdown_expiry: got expired %b done %b count %0d expected 1 1 0", expired, done, count);
    end
    npulse += int'(expired);
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (expired) npulse++;
    end
    checks++; if (count !== 7'd0 || done !== 1'b1) begin
      errors++; $display("FAIL countdown_hold: got count %0d done %b expected 0 1", count, done);
    end
    checks++; if (npulse != 1) begin errors++; $display("FAIL countdown_pulses: got %0d expected 1", npulse); end
  endtask

  task automatic test_pause();
    load_value = 7'd3; load = 1'b1; cycle(); load = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    for (int j = 0; j < TICK_DIV; j++) cycle();
    checks++; if (count !== 7'd2) begin errors++; $display("FAIL pause_first_step: got %0d expected 2", count); end
    cycle();
    pause = 1'b1;
    for (int j = 0; j < 10; j++) begin
      cycle();
      checks++; if (count !== 7'd2 || running !== 1'b0) begin
        errors++; $display("FAIL pause_hold: got count %0d running %b expected 2 0", count, running);
      end
    end
    pause = 1'b0; start = 1'b1; cycle(); start = 1'b0;
    cycle(); cycle();
    checks++; if (count !== 7'd2 || running !== 1'b1) begin
      errors++; $display("FAIL pause_resume_pre: got count %0d running %b expected 2 1", count, running);
    end
    cycle();
    checks++; if (count !== 7'd1) begin errors++; $display("FAIL pause_phase_kept: got %0d expected 1", count); end
  endtask

  task automatic test_auto_reload();
    int seq[$];
    int last;
    int want[6] = '{2, 1, 0, 2, 1, 0};
    auto_reload = 1'b1;
    load_value = 7'd2; load = 1'b1; cycle(); load = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    last = -1;
    for (int idx = 0; idx < 26; idx++) begin
      if (int'(count) != last) begin last = int'(count); seq.push_back(last); end
      checks++; if (expired !== ((idx > 0 && idx % 8 == 0) ? 1'b1 : 1'b0) || done !== 1'b0) begin
        errors++; $display("FAIL reload_timing: idx %0d got expired %b done %b", idx, expired, done);
      end
      cycle();
    end
    checks++; if (seq.size() < 6) begin
      errors++; $display("FAIL reload_seq_len: got %0d expected >= 6", seq.size());
    end else begin
      for (int i = 0; i < 6; i++) if (seq[i] != want[i]) begin
        errors++; $display("FAIL reload_seq: index %0d got %0d expected %0d", i, seq[i], want[i]);
      end
    end
    auto_reload = 1'b0;
  endtask

  task automatic test_zero_load();
    for (int ar = 0; ar < 2; ar++) begin
      auto_reload = ar[0];
      load_value = 7'd0; load = 1'b1; cycle(); load = 1'b0;
      start = 1'b1; cycle(); start = 1'b0;
      checks++; if (expired !== 1'b1 || done !== 1'b1 || running !== 1'b0 || count !== 7'd0) begin
        errors++; $display("FAIL zero_load ar=%0d: got exp %b done %b run %b count %0d expected 1 1 0 0",
                           ar, expired, done, running, count);
      end
      cycle();
      checks++; if (expired !== 1'b0 || done !== 1'b1) begin
        errors++; $display("FAIL zero_load_after ar=%0d: got exp %b done %b expected 0 1", ar, expired, done);
      end
    end
    auto_reload = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int n;
    bit seen;
    seen = 0; n = 0;
    load_value = 7'd7; load = 1'b1; cycle(); load = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    while (count !== 7'd5 && n < 40) begin cycle(); n++; if (expired) seen = 1; end
    checks++; if (count !== 7'd5) begin errors++; $display("FAIL midrun_reach5: got %0d expected 5", count); end
    reset = 1'b1; model_reset();
    #1;
    checks++; if (count !== 7'(INIT) || running !== 1'b0 || expired !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL midrun_reset: got count %0d run %b exp %b done %b expected %0d 0 0 0",
                         count, running, expired, done, INIT);
    end
    cycle(); reset = 1'b0;
    for (int k = 0; k < 8; k++) begin cycle(); if (expired) seen = 1; end
    checks++; if (count !== 7'(INIT) || running !== 1'b0 || seen) begin
      errors++; $display("FAIL midrun_wait: got count %0d run %b pulse %b expected %0d 0 0", count, running, seen, INIT);
    end
  endtask

  task automatic test_load_final_tick();
    load_value = 7'd1; load = 1'b1; cycle(); load = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    cycle(); cycle(); cycle();
    load_value = 7'd5; load = 1'b1; cycle(); load = 1'b0;
    checks++; if (count !== 7'd5 || expired !== 1'b0 || running !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL load_on_tick: got count %0d exp %b run %b done %b expected 5 0 0 0",
                         count, expired, running, done);
    end
    cycle();
    checks++; if (expired !== 1'b0 || count !== 7'd5) begin
      errors++; $display("FAIL load_on_tick_after: got exp %b count %0d expected 0 5", expired, count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      load        = ($urandom_range(0, 99) < 4);
      load_value  = 7'($urandom_range(0, 6));
      start       = ($urandom_range(0, 99) < 12);
      pause       = ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 99) < 5) auto_reload = ~auto_reload;
      cycle();
      checks++; if (count !== 7'(m_count) || running !== (m_state == S_RUN) ||
                    done !== (m_state == S_DONE) || expired !== m_expired[0]) begin
        errors++; $display("FAIL random cyc %0d: got count %0d run %b done %b exp %b expected %0d %b %b %b",
                           i, count, running, done, expired, m_count, m_state == S_RUN, m_state == S_DONE, m_expired[0]);
      end
    end
    load = 1'b0; start = 1'b0; pause = 1'b0;
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_pause();
    test_auto_reload();
    test_zero_load();
    test_reset_midrun();
    test_load_final_tick();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
